circular_buffer_reader: RTL

Read-side sequencer for the sample circular buffer. On each `start` pulse it walks the buffer memory's read port backwards from the newest written address (`head`) through all `DEPTH` entries, newest to oldest. It hides the memory's one-cycle read latency and streams words out on a valid/ready interface with `dataLast`. It feeds the downstream filter/tap stage that consumes the sample window after every write.

---
 rtl/circular_buffer_pkg.sv | 25 ++
 rtl/reader_skid_fifo.sv | 52 +++++
 rtl/circular_buffer_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/circular_buffer_pkg.sv
// Shared definitions for the sample circular buffer read side:
// buffer geometry, the clogb2 helper and the reader state encoding.
package circular_buffer_pkg;

   // Ceiling log2, used to size buffer addresses.
   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   localparam int DEPTH        = 16;
   localparam int WORDWIDTH    = 18;
   localparam int ADDRESSWIDTH = clogb2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } reader_state_t;

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs words returned by the buffer
// memory while the consumer stalls. entry0 is always the head.
module reader_skid_fifo
   import circular_buffer_pkg::*;
#(
   parameter int WIDTH = WORDWIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic signed [WIDTH-1:0] push_data,
   output logic [1:0]              count,
   output logic signed [WIDTH-1:0] head_data
);

   logic signed [WIDTH-1:0] entry0;
   logic signed [WIDTH-1:0] entry1;

   // Occupancy and storage update; entries shift toward entry0 on pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) entry0 <= push_data;
               else               entry1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  entry0 <= entry1;
                  entry1 <= push_data;
               end else begin
                  entry0 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data = entry0;

endmodule

// File: rtl/circular_buffer_reader.sv
// Read-side sequencer for the sample circular buffer. Each accepted start
// walks the buffer newest-to-oldest from head, hides the one-cycle memory
// latency behind a 2-entry skid FIFO and streams words on valid/ready.
// Optional window sum: define CB_READER_SUM_EN.
module circular_buffer_reader
   import circular_buffer_pkg::*;
#(
   parameter int DEPTH        = circular_buffer_pkg::DEPTH,
   parameter int WORDWIDTH    = circular_buffer_pkg::WORDWIDTH,
   parameter int ADDRESSWIDTH = clogb2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ADDRESSWIDTH-1:0]        head,
   output logic                           busy,
   output logic [ADDRESSWIDTH-1:0]        memAddr,
   output logic                           memReadEnable,
   input  logic signed [WORDWIDTH-1:0]    memData,
   output logic signed [WORDWIDTH-1:0]    dataOut,
   output logic                           dataValid,
   output logic                           dataLast,
   input  logic                           dataReady
`ifdef CB_READER_SUM_EN
   ,
   output logic signed [WORDWIDTH+ADDRESSWIDTH-1:0] sumOut,
   output logic                                     sumValid
`endif
);

   localparam logic [ADDRESSWIDTH-1:0] LAST_INDEX = ADDRESSWIDTH'(DEPTH - 1);

   reader_state_t           state;
   logic [ADDRESSWIDTH-1:0] addr;
   logic [ADDRESSWIDTH-1:0] issue_cnt;
   logic [ADDRESSWIDTH-1:0] out_cnt;
   logic                    in_flight;
   logic [1:0]              fifo_count;
   logic [2:0]              pending;
   logic                    pop;
   logic                    accept;

   reader_skid_fifo #(
      .WIDTH(WORDWIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_flight),
      .pop      (pop),
      .push_data(memData),
      .count    (fifo_count),
      .head_data(dataOut)
   );

   // Handshake, credit check and issue decision. A read may only be issued
   // if its word is guaranteed a FIFO slot when it returns.
   always_comb begin
      dataValid     = (fifo_count != 2'd0);
      pop           = dataValid && dataReady;
      dataLast      = dataValid && (out_cnt == LAST_INDEX);
      accept        = (state == IDLE) && start;
      pending       = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
      memReadEnable = (state == READ) && (pending < 3'd2);
      busy          = (state != IDLE);
      memAddr       = addr;
   end

   // Window FSM with read-address walk, issue count and output-word count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         issue_cnt <= '0;
         out_cnt   <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= memReadEnable;
         if (memReadEnable) begin
            addr      <= addr - 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (pop) out_cnt <= out_cnt + 1'b1;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= READ;
                  addr      <= head;
                  issue_cnt <= '0;
                  out_cnt   <= '0;
               end
            end
            READ: begin
               if (memReadEnable && (issue_cnt == LAST_INDEX)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && dataLast) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CB_READER_SUM_EN
   localparam int SUMWIDTH = WORDWIDTH + ADDRESSWIDTH;

   logic signed [SUMWIDTH-1:0] acc;

   // Window accumulator; the result is published one cycle after the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         sumOut   <= '0;
         sumValid <= 1'b0;
      end else begin
         sumValid <= 1'b0;
         if (accept) acc <= '0;
         else if (pop) acc <= acc + SUMWIDTH'(dataOut);
         if (pop && dataLast) begin
            sumOut   <= acc + SUMWIDTH'(dataOut);
            sumValid <= 1'b1;
         end
      end
   end
`endif

endmodule
